// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: phase codes, lamp patterns
// and lamp bit positions within each direction's 3-bit ryg field.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_CLEAR  = 2'd2,
    PH_EMERG  = 2'd3
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  localparam int RED = 2;
  localparam int YEL = 1;
  localparam int GRN = 0;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin selector: first direction with demand after
// active_dir (wrapping, active_dir itself last), else simply active_dir+1.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter int N_DIR = 2,
  parameter int DIRW  = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic [N_DIR-1:0] demand,
  input  logic [DIRW-1:0]  active_dir,
  output logic [DIRW-1:0]  next_dir
);

  logic [DIRW-1:0] cand;
  logic [DIRW-1:0] plus_one;
  logic            found;

  always_comb begin
    plus_one = (active_dir == DIRW'(N_DIR - 1)) ? '0 : active_dir + DIRW'(1);
    next_dir = plus_one;
    cand     = active_dir;
    found    = 1'b0;
    for (int i = 0; i < N_DIR; i++) begin
      cand = (cand == DIRW'(N_DIR - 1)) ? '0 : cand + DIRW'(1);
      if (!found && demand[cand]) begin
        next_dir = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic phase controller: GREEN -> YELLOW -> CLEAR rotation with
// demand skipping, emergency all-red and a freezing lamp test. All outputs registered.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR = 2,
  parameter int TW    = 8,
  parameter int DIRW  = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_DIR*TW-1:0] green_time,
  input  logic [TW-1:0]       yellow_time,
  input  logic [TW-1:0]       clear_time,
  input  logic [N_DIR-1:0]    demand,
  input  logic                emergency,
  input  logic                test,
  output logic [N_DIR*3-1:0]  ryg,
  output logic [DIRW-1:0]     active_dir,
  output logic [1:0]          phase,
  output logic [TW-1:0]       remain
);

  phase_t               state, state_n;
  logic [TW-1:0]        remain_n;
  logic [DIRW-1:0]      dir_n;
  logic [DIRW-1:0]      pick;
  logic [TW-1:0]        green_sel;
  logic [N_DIR*3-1:0]   ryg_n;

  traffic_rr_pick #(
    .N_DIR (N_DIR),
    .DIRW  (DIRW)
  ) u_pick (
    .demand     (demand),
    .active_dir (active_dir),
    .next_dir   (pick)
  );

  always_comb begin
    green_sel = '0;
    for (int d = 0; d < N_DIR; d++) begin
      if (pick == DIRW'(d)) green_sel = green_time[d*TW +: TW];
    end
  end

  // Priority: test freezes everything, then emergency, then the countdown.
  always_comb begin
    state_n  = state;
    remain_n = remain;
    dir_n    = active_dir;
    if (test) begin
      state_n = state;
    end else if (emergency) begin
      state_n  = PH_EMERG;
      remain_n = '0;
    end else if (state == PH_EMERG) begin
      state_n  = PH_CLEAR;
      remain_n = clear_time;
    end else if (tick) begin
      if (remain > TW'(1)) begin
        remain_n = remain - TW'(1);
      end else begin
        case (state)
          PH_GREEN: begin
            state_n  = PH_YELLOW;
            remain_n = yellow_time;
          end
          PH_YELLOW: begin
            state_n  = PH_CLEAR;
            remain_n = clear_time;
          end
          PH_CLEAR: begin
            state_n  = PH_GREEN;
            dir_n    = pick;
            remain_n = green_sel;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  // Lamps are decoded from the next state so they update on the same edge.
  always_comb begin
    ryg_n = '0;
    for (int d = 0; d < N_DIR; d++) begin
      if (test)
        ryg_n[d*3 +: 3] = LAMP_ALL;
      else if (dir_n == DIRW'(d) && state_n == PH_GREEN)
        ryg_n[d*3 +: 3] = LAMP_GRN;
      else if (dir_n == DIRW'(d) && state_n == PH_YELLOW)
        ryg_n[d*3 +: 3] = LAMP_YEL;
      else
        ryg_n[d*3 +: 3] = LAMP_RED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PH_CLEAR;
      remain     <= '0;
      active_dir <= DIRW'(N_DIR - 1);
      ryg        <= {N_DIR{LAMP_RED}};
    end else begin
      state      <= state_n;
      remain     <= remain_n;
      active_dir <= dir_n;
      ryg        <= ryg_n;
    end
  end

  assign phase = state;

endmodule
